rob_nway: RTL
=============

// Module: rob_nway
// PURPOSE
//  Parametrised reorder buffer for the OoO core: N-wide in-order dispatch, multi-port CDB completion marking,
//  multi-wide in-order retire, and single-cycle branch-mispredict squash by ROB index.
//  Sits between dispatch (allocates entries), the CDB (marks entries done) and retire (consumes from head).
//  Successor to the fixed-N ROB: widths decoupled per stage, explicit occupancy counter, per-entry done tracking.
// PARAMETERS
//  ROB_SZ      32  entries; power of two, >=4
//  DISPATCH_W   3  max entries allocated per cycle
//  RETIRE_W     3  max entries retired per cycle
//  CDB_W        3  completion ports per cycle
//  PAYLOAD_W   32  opaque per-entry payload bits (ROB_ENTRY_PACKET width)
//  derived: IDX_W=$clog2(ROB_SZ); CNT_W=$clog2(max(DISPATCH_W,RETIRE_W)+1)
// PORTS
//  clock          in   1                    single clock, all state on posedge
//  reset          in   1                    synchronous, active-high
//  disp_valid     in   CNT_W                count of valid dispatch lanes; lanes 0..disp_valid-1, oldest first
//  disp_payload   in   DISPATCH_W*PAYLOAD_W payload per lane
//  disp_spots     out  CNT_W                min(DISPATCH_W, ROB_SZ-num_entries)
//  disp_idx       out  DISPATCH_W*IDX_W     index assigned to lane i = (tail+i) mod ROB_SZ
//  cdb_valid      in   CDB_W                per-port completion strobe
//  cdb_idx        in   CDB_W*IDX_W          ROB index completing on each port
//  ret_payload    out  RETIRE_W*PAYLOAD_W   payload of entry (head+i) mod ROB_SZ
//  ret_ready      out  CNT_W                consecutive valid&done entries from head, capped at RETIRE_W
//  ret_count      in   CNT_W                entries retired this cycle; must be <= ret_ready
//  restore_valid  in   1                    mispredict squash strobe
//  restore_idx    in   IDX_W                index of mispredicted branch; all younger entries squashed
//  head           out  IDX_W                oldest entry index
//  tail           out  IDX_W                next allocation index
//  num_entries    out  IDX_W+1              occupancy, 0..ROB_SZ
// BEHAVIOUR
//  - State: payload[ROB_SZ], valid[ROB_SZ], done[ROB_SZ], head, tail, num_entries (removes head==tail ambiguity).
//  - Reset: head=tail=0, num_entries=0, all valid/done=0; so disp_spots=DISPATCH_W, ret_ready=0 in the first cycle.
//  - disp_spots, disp_idx, ret_ready, ret_payload: combinational from current registered state only (0-cycle).
//  - Dispatch: requires disp_valid<=disp_spots (same-cycle retirement does NOT add spots). Each lane i<disp_valid
//    writes payload, sets valid=1, done=0 at (tail+i) mod ROB_SZ; tail+=disp_valid mod ROB_SZ.
//  - Completion: each cdb port with cdb_valid sets done[cdb_idx] next cycle iff valid[cdb_idx]=1; else ignored.
//    Duplicate indices across ports allowed (idempotent). Visible in ret_ready one cycle after strobe.
//  - Retire: clears valid/done for ret_count entries from head; head+=ret_count mod ROB_SZ.
//  - Occupancy: num_entries_next = num_entries + disp_valid - ret_count (no restore).
//  - Restore (priority over dispatch): dispatch lanes ignored that cycle; CDB writes to squashed entries dropped;
//    retirement in the same cycle honoured; constraint ret_count <= ((restore_idx-head) mod ROB_SZ)+1.
//    tail_next = (restore_idx+1) mod ROB_SZ; head_next = head+ret_count;
//    num_entries_next = ((restore_idx-head) mod ROB_SZ)+1-ret_count; valid/done cleared for every squashed index.
//  - Wrap-around: all index arithmetic modulo ROB_SZ via IDX_W-bit truncation; ret_ready scan wraps past ROB_SZ-1.
//  - Full: num_entries==ROB_SZ -> disp_spots=0, tail==head. Empty: num_entries==0 -> ret_ready=0, tail==head.
//  - Reset mid-operation: discards all entries, in-flight CDB strobes and restore in that cycle.
//  - Protocol violations (disp_valid>disp_spots, ret_count>ret_ready): flagged by SVA, RTL behaviour undefined.
// TESTING (ROB_SZ=8, DISPATCH_W=RETIRE_W=CDB_W=3)
//  1. Reset held 2 cycles -> head=tail=0, num_entries=0, disp_spots=3, ret_ready=0.
//  2. Dispatch 3,3,2 on consecutive cycles -> 3rd cycle disp_idx lanes0/1={6,7}; then tail=0, num_entries=8, disp_spots=0.
//  3. CDB idx 2 and 1 -> ret_ready=0; CDB idx 0 next -> ret_ready=3 following cycle; ret_count=3 -> head=3, num_entries=5.
//  4. head=6, 4 entries (6,7,0,1) all done -> ret_ready=3, ret_payload = entries 6,7,0; ret_count=3 -> head=1.
//  5. head=1, num_entries=6, restore_idx=3 with ret_count=1 -> head=2, tail=4, num_entries=2; next-cycle CDB idx 5 ignored.
//  6. num_entries=7, disp_spots=1, dispatch 1 + ret_count=3 same cycle -> num_entries=5, tail advances 1, head advances 3.

Source files
------------

// File: rtl/rob_nway.sv
// rob_nway: N-wide reorder buffer with in-order dispatch, multi-port CDB completion,
// multi-wide in-order retire and single-cycle mispredict squash by ROB index.
module rob_nway #(
    parameter int ROB_SZ     = 32,
    parameter int DISPATCH_W = 3,
    parameter int RETIRE_W   = 3,
    parameter int CDB_W      = 3,
    parameter int PAYLOAD_W  = 32,
    localparam int IDX_W     = $clog2(ROB_SZ),
    localparam int CNT_W     = $clog2((DISPATCH_W > RETIRE_W ? DISPATCH_W : RETIRE_W) + 1)
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic [CNT_W-1:0]                i_disp_valid,
    input  logic [DISPATCH_W*PAYLOAD_W-1:0] i_disp_payload,
    output logic [CNT_W-1:0]                o_disp_spots,
    output logic [DISPATCH_W*IDX_W-1:0]     o_disp_idx,
    input  logic [CDB_W-1:0]                i_cdb_valid,
    input  logic [CDB_W*IDX_W-1:0]          i_cdb_idx,
    output logic [RETIRE_W*PAYLOAD_W-1:0]   o_ret_payload,
    output logic [CNT_W-1:0]                o_ret_ready,
    input  logic [CNT_W-1:0]                i_ret_count,
    input  logic                            i_restore_valid,
    input  logic [IDX_W-1:0]                i_restore_idx,
    output logic [IDX_W-1:0]                o_head,
    output logic [IDX_W-1:0]                o_tail,
    output logic [IDX_W:0]                  o_num_entries
);
    logic [PAYLOAD_W-1:0] r_payload [ROB_SZ];
    logic [ROB_SZ-1:0]    r_valid, r_done;
    logic [IDX_W-1:0]     r_head, r_tail;
    logic [IDX_W:0]       r_num;
    logic [IDX_W-1:0]     w_disp_idx [DISPATCH_W];
    logic [ROB_SZ-1:0]    w_valid_nxt, w_done_nxt;
    logic [IDX_W-1:0]     w_rel, w_off, w_ri, w_ci;
    logic [IDX_W:0]       w_free, w_num_nxt;
    logic                 w_run;

    assign o_head        = r_head;
    assign o_tail        = r_tail;
    assign o_num_entries = r_num;
    assign w_rel         = i_restore_idx - r_head;
    assign w_free        = (IDX_W+1)'(ROB_SZ) - r_num;
    assign o_disp_spots  = w_free >= (IDX_W+1)'(DISPATCH_W) ? CNT_W'(DISPATCH_W) : CNT_W'(w_free);
    assign w_num_nxt     = i_restore_valid
                         ? (IDX_W+1)'(w_rel) + 1'b1 - (IDX_W+1)'(i_ret_count)
                         : r_num + (IDX_W+1)'(i_disp_valid) - (IDX_W+1)'(i_ret_count);

    for (genvar d = 0; d < DISPATCH_W; d++) begin : g_disp
        assign w_disp_idx[d]                   = r_tail + IDX_W'(d);
        assign o_disp_idx[d*IDX_W +: IDX_W]    = w_disp_idx[d];
    end

    for (genvar r = 0; r < RETIRE_W; r++) begin : g_ret
        assign o_ret_payload[r*PAYLOAD_W +: PAYLOAD_W] = r_payload[r_head + IDX_W'(r)];
    end

    // Retire readiness stops at the first entry from head that is not both valid and done.
    always_comb begin
        o_ret_ready = '0;
        w_run       = 1'b1;
        w_ri        = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            w_ri  = r_head + IDX_W'(i);
            w_run = w_run && r_valid[w_ri] && r_done[w_ri];
            if (w_run) o_ret_ready = o_ret_ready + 1'b1;
        end
    end

    // Completion first, then retire/squash clears, so CDB hits on leaving entries are dropped.
    always_comb begin
        w_valid_nxt = r_valid;
        w_done_nxt  = r_done;
        w_off       = '0;
        w_ci        = '0;
        for (int c = 0; c < CDB_W; c++) begin
            w_ci = i_cdb_idx[c*IDX_W +: IDX_W];
            if (i_cdb_valid[c] && r_valid[w_ci]) w_done_nxt[w_ci] = 1'b1;
        end
        for (int k = 0; k < ROB_SZ; k++) begin
            w_off = IDX_W'(k) - r_head;
            if (w_off < IDX_W'(i_ret_count) || (i_restore_valid && w_off > w_rel)) begin
                w_valid_nxt[k] = 1'b0;
                w_done_nxt[k]  = 1'b0;
            end
        end
        for (int i = 0; i < DISPATCH_W; i++) begin
            if (!i_restore_valid && i < int'(i_disp_valid)) begin
                w_valid_nxt[w_disp_idx[i]] = 1'b1;
                w_done_nxt[w_disp_idx[i]]  = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valid <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_num   <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
            r_head  <= r_head + IDX_W'(i_ret_count);
            r_tail  <= i_restore_valid ? i_restore_idx + 1'b1 : r_tail + IDX_W'(i_disp_valid);
            r_num   <= w_num_nxt;
        end
    end

    always_ff @(posedge i_clock) begin
        for (int i = 0; i < DISPATCH_W; i++) begin
            if (!i_reset && !i_restore_valid && i < int'(i_disp_valid))
                r_payload[w_disp_idx[i]] <= i_disp_payload[i*PAYLOAD_W +: PAYLOAD_W];
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            assert (i_restore_valid || i_disp_valid <= o_disp_spots);
            assert (i_ret_count <= o_ret_ready);
            assert (!i_restore_valid || (IDX_W+1)'(i_ret_count) <= (IDX_W+1)'(w_rel) + 1'b1);
        end
    end
endmodule
